if_fetch_ctrl: RTL



---
 rtl/if_fetch_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch sequencer.
//   Owns the PC and issues sequential word reads to a 1-cycle synchronous
//   instruction memory. Returned words are buffered in a 2-entry FIFO that
//   feeds decode over a valid/ready handshake. Branch redirects squash
//   everything buffered or in flight. A program loader can take over the
//   memory port at any time and has priority over fetch.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   redirect_valid/_pc         redirect pulse and byte target
//   ld_we/ld_addr/ld_wdata     loader write request (passed straight to memory)
//   imem_req/we/addr/wdata     memory command; imem_rdata returns a cycle after imem_req
//   if_valid/if_instr/if_pc    decode-side output, registered from the FIFO head
//   if_ready                   decode accept
//   fetch_fault                sticky bad-redirect flag, cleared by a load session
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        imem_req,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {RUN, LOAD, FAULT} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t       state;
  logic [31:0]  pc;
  logic         inflight;     // a read was issued last cycle; its data is on imem_rdata now
  logic [31:0]  inflight_pc;
  entry_t [1:0] fifo;
  logic         rd_ptr, wr_ptr;
  logic [1:0]   count;

  logic       pop, issue, bad_target;
  logic [2:0] committed;

  assign if_valid = (count != 2'd0);
  assign if_instr = fifo[rd_ptr].instr;
  assign if_pc    = fifo[rd_ptr].pc;

  assign pop = if_valid & if_ready;

  // Slots already spoken for once this cycle's pop is taken into account.
  // pop implies count >= 1, so this never underflows.
  assign committed = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  // rst_n gates the combinational command outputs so nothing reaches memory
  // while reset is asserted, even with ld_we or a stale state.
  assign issue = rst_n & (state == RUN) & !redirect_valid & !ld_we & (committed < 3'd2);

  assign bad_target = (redirect_pc[1:0] != 2'b00) || ((redirect_pc >> 2) >= DEPTH_WORDS);

  assign imem_req   = issue;
  assign imem_we    = rst_n & ld_we;
  assign imem_addr  = imem_we ? ld_addr : (issue ? pc : 32'h0);
  assign imem_wdata = imem_we ? ld_wdata : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fifo        <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      fetch_fault <= 1'b0;
    end else if (ld_we) begin
      // Loader owns the port: drop everything buffered or in flight.
      state       <= LOAD;
      inflight    <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      fetch_fault <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          state <= RUN;
          pc    <= RESET_PC;
        end
        FAULT: ;
        RUN: begin
          if (redirect_valid) begin
            // Squash: the response arriving this cycle is not written.
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            if (bad_target) begin
              state       <= FAULT;
              fetch_fault <= 1'b1;
            end else begin
              pc <= redirect_pc;
            end
          end else begin
            inflight    <= issue;
            inflight_pc <= pc;
            if (issue) pc <= pc + 32'd4;
            if (inflight) begin
              fifo[wr_ptr] <= {inflight_pc, imem_rdata};
              wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
